dma_desc_queue: RTL and testbench

Descriptor queue and sequencer that sits directly upstream of the DMA engine's register port. The CPU stages one 10-byte transfer descriptor, commits it into a DEPTH-entry FIFO, and continues with other work. The sequencer pops descriptors one at a time, replays them as register writes into the idle engine, and waits for completion before issuing the next. It raises a sticky DONE flag and an optional IRQ for each completed descriptor.

---
 rtl/dma_pkg.sv | 70 +++++++
 rtl/dma_desc_fifo.sv | 78 +++++++
 rtl/dma_desc_queue.sv | 194 +++++++++++++++++++
 tb/tb_dma_desc_queue.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA descriptor queue.
//   - engine register offsets (5-bit engine register port)
//   - CPU-side queue map offsets (commit and status/control)
//   - 80-bit descriptor type, sadd in the low 16 bits so that byte N of the
//     flattened vector is engine register offset N
//   - sequencer state enum and byte-access helpers
package dma_pkg;

    localparam logic [4:0] SADD_L  = 5'h00;
    localparam logic [4:0] SADD_H  = 5'h01;
    localparam logic [4:0] SINC_L  = 5'h02;
    localparam logic [4:0] SINC_H  = 5'h03;
    localparam logic [4:0] DADD_L  = 5'h04;
    localparam logic [4:0] DADD_H  = 5'h05;
    localparam logic [4:0] DINC_L  = 5'h06;
    localparam logic [4:0] DINC_H  = 5'h07;
    localparam logic [4:0] COUNT_L = 5'h08;
    localparam logic [4:0] COUNT_H = 5'h09;

    localparam logic [3:0] COMMIT = 4'hA;
    localparam logic [3:0] STATUS = 4'hB;

    localparam int DESC_BYTES = 10;

    typedef struct packed {
        logic [15:0] count;
        logic [15:0] dinc;
        logic [15:0] dadd;
        logic [15:0] sinc;
        logic [15:0] sadd;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE,
        FINISH
    } seq_state_t;

    // Replay order: count hi goes before count lo because the engine
    // starts on the count-lo write and must already hold the full count.
    function automatic logic [3:0] load_offset(logic [3:0] idx);
        case (idx)
            4'd8:    load_offset = COUNT_H[3:0];
            4'd9:    load_offset = COUNT_L[3:0];
            default: load_offset = idx;
        endcase
    endfunction

    // Byte N of a descriptor; offsets outside the descriptor read as zero.
    function automatic logic [7:0] desc_byte(desc_t d, logic [3:0] off);
        logic [79:0] flat;
        flat = d;
        desc_byte = 8'h00;
        for (int i = 0; i < DESC_BYTES; i++) begin
            if (off == 4'(i)) desc_byte = flat[i*8 +: 8];
        end
    endfunction

    function automatic desc_t desc_set_byte(desc_t d, logic [3:0] off, logic [7:0] b);
        logic [79:0] flat;
        flat = d;
        for (int i = 0; i < DESC_BYTES; i++) begin
            if (off == 4'(i)) flat[i*8 +: 8] = b;
        end
        return desc_t'(flat);
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: synchronous DEPTH x 80-bit descriptor FIFO, no bypass.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write din at the tail when not full
//   pop        : drop the head entry when not empty
//   head       : current head entry (valid while !empty)
//   full, empty: occupancy flags of the current state
//   level      : number of stored entries, 0..DEPTH
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  desc_t                    din,
    output desc_t                    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    desc_t           mem_q [DEPTH];
    desc_t           mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign level   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dma_desc_queue.sv
// dma_desc_queue: CPU-staged descriptor queue feeding the DMA engine's
// register port. The CPU fills a 10-byte staging area, commits it into the
// FIFO, and the sequencer replays each descriptor as engine register writes,
// then waits for the engine to finish before taking the next one.
//   PHI2, RESET          : clock, synchronous active-high reset
//   CS, RWB, ADDR, DIN   : CPU register access (RWB=1 write)
//   DOUT                 : CPU read data, combinational
//   ENG_BUSY             : engine busy (owns the bus)
//   ENG_CS/RWB/ADDR/DATA : registered engine register-write port
//   IRQ                  : DONE && IRQEN
module dma_desc_queue
    import dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       PHI2,
    input  logic       RESET,
    input  logic       CS,
    input  logic       RWB,
    input  logic [3:0] ADDR,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    input  logic       ENG_BUSY,
    output logic       ENG_CS,
    output logic       ENG_RWB,
    output logic [4:0] ENG_ADDR,
    output logic [7:0] ENG_DATA,
    output logic       IRQ
);

    localparam int LW = $clog2(DEPTH) + 1;

    desc_t        staging_q, staging_d;
    logic         irqen_q, irqen_d;
    logic         ovf_q, ovf_d;
    logic         done_q, done_d;
    seq_state_t   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [1:0]   wd_q, wd_d;
    logic         eng_cs_q, eng_cs_d;
    logic         eng_rwb_q;
    logic [4:0]   eng_addr_q, eng_addr_d;
    logic [7:0]   eng_data_q, eng_data_d;

    logic         cpu_wr, cpu_rd;
    logic         fifo_push, fifo_pop;
    logic         fifo_full, fifo_empty;
    desc_t        fifo_head;
    logic [LW-1:0] fifo_level;
    logic [4:0]   level_ext;
    logic [2:0]   level_sat;
    logic [7:0]   status;
    logic [3:0]   load_off;

    assign cpu_wr    = CS && RWB;
    assign cpu_rd    = CS && !RWB;
    // Full is the pre-pop occupancy, so a commit while full is always dropped.
    assign fifo_push = cpu_wr && (ADDR == COMMIT) && !fifo_full;

    dma_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (PHI2),
        .rst   (RESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (staging_q),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign level_ext = 5'(fifo_level);
    assign level_sat = (level_ext > 5'd7) ? 3'd7 : level_ext[2:0];
    assign status    = {irqen_q, ovf_q, done_q, fifo_full, fifo_empty, level_sat};

    // CPU read mux; anything that is not staging or status reads as zero.
    always_comb begin
        DOUT = 8'h00;
        if (cpu_rd) begin
            if (ADDR == STATUS) DOUT = status;
            else                DOUT = desc_byte(staging_q, ADDR);
        end
    end

    // CPU-visible registers. The FINISH set of DONE comes after the CPU
    // clear so that a same-cycle completion is never lost.
    always_comb begin
        staging_d = staging_q;
        irqen_d   = irqen_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        if (cpu_wr && (ADDR < 4'd10)) begin
            staging_d = desc_set_byte(staging_q, ADDR, DIN);
        end
        if (cpu_wr && (ADDR == COMMIT) && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (cpu_wr && (ADDR == STATUS)) begin
            irqen_d = DIN[7];
            if (DIN[6]) ovf_d  = 1'b0;
            if (DIN[5]) done_d = 1'b0;
        end
        if (state_q == FINISH) begin
            done_d = 1'b1;
        end
    end

    // Sequencer next state and registered engine-port values. Address and
    // data hold their last value between bursts; only the strobe drops.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        eng_cs_d   = 1'b0;
        eng_addr_d = eng_addr_q;
        eng_data_d = eng_data_q;
        fifo_pop   = 1'b0;
        load_off   = load_offset(idx_q);
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !ENG_BUSY) begin
                    state_d = LOAD;
                    idx_d   = 4'd0;
                end
            end
            LOAD: begin
                eng_cs_d   = 1'b1;
                eng_addr_d = {1'b0, load_off};
                eng_data_d = desc_byte(fifo_head, load_off);
                if (idx_q == 4'd9) begin
                    fifo_pop = 1'b1;
                    wd_d     = 2'd0;
                    // A zero count never starts the engine, so skip the wait.
                    state_d  = (fifo_head.count == 16'h0000) ? FINISH : WAIT_START;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            WAIT_START: begin
                if (ENG_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (wd_q == 2'd3) begin
                    state_d = FINISH;
                end else begin
                    wd_d = wd_q + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!ENG_BUSY) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PHI2) begin
        if (RESET) begin
            staging_q  <= '0;
            irqen_q    <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            wd_q       <= 2'd0;
            eng_cs_q   <= 1'b0;
            eng_rwb_q  <= 1'b0;
            eng_addr_q <= 5'd0;
            eng_data_q <= 8'h00;
        end else begin
            staging_q  <= staging_d;
            irqen_q    <= irqen_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            eng_cs_q   <= eng_cs_d;
            eng_rwb_q  <= eng_cs_d;
            eng_addr_q <= eng_addr_d;
            eng_data_q <= eng_data_d;
        end
    end

    assign ENG_CS   = eng_cs_q;
    assign ENG_RWB  = eng_rwb_q;
    assign ENG_ADDR = eng_addr_q;
    assign ENG_DATA = eng_data_q;
    assign IRQ      = done_q && irqen_q;

endmodule

// File: tb/tb_dma_desc_queue.sv
// tb_dma_desc_queue: scoreboard bench for dma_desc_queue. Every accepted
// commit pushes its ten expected engine writes; a monitor pops one entry per
// observed ENG_CS. A small engine model raises ENG_BUSY after a non-zero
// count-lo write. Status reads are checked against a model of the queue.
module tb_dma_desc_queue;
    import dma_pkg::*;

    localparam int TB_DEPTH = 4;

    logic       PHI2 = 1'b0;
    logic       RESET;
    logic       CS;
    logic       RWB;
    logic [3:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       ENG_BUSY;
    logic       ENG_CS;
    logic       ENG_RWB;
    logic [4:0] ENG_ADDR;
    logic [7:0] ENG_DATA;
    logic       IRQ;

    logic       busyEngine = 1'b0;
    logic       busyForce  = 1'b0;
    assign ENG_BUSY = busyEngine | busyForce;

    int          errors = 0;
    int          checks = 0;
    logic [12:0] expQ [$];
    logic [12:0] expEntry;
    logic [7:0]  stageM [10];
    int          pendingM = 0;
    bit          irqenM = 1'b0;
    bit          ovfM = 1'b0;
    int          engineStarts = 0;
    int          busyTimer = 0;
    logic [7:0]  cntHi = 8'h00;
    int          order [10];

    dma_desc_queue #(.DEPTH(TB_DEPTH)) dut (
        .PHI2     (PHI2),
        .RESET    (RESET),
        .CS       (CS),
        .RWB      (RWB),
        .ADDR     (ADDR),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .ENG_BUSY (ENG_BUSY),
        .ENG_CS   (ENG_CS),
        .ENG_RWB  (ENG_RWB),
        .ENG_ADDR (ENG_ADDR),
        .ENG_DATA (ENG_DATA),
        .IRQ      (IRQ)
    );

    // Free-running clock, period 10.
    always #5 PHI2 = ~PHI2;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor first (so the busy check sees the pre-write engine state),
    // then the engine model: busy for a random 1..6 cycles after any
    // count-lo write that carries a non-zero 16-bit count.
    always @(negedge PHI2) begin
        if (ENG_CS === 1'b1) begin
            checkOutput("eng_busy_during_write", 32'(ENG_BUSY), 32'd0);
            checkOutput("eng_rwb", 32'(ENG_RWB), 32'd1);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", ENG_ADDR, ENG_DATA);
            end else begin
                expEntry = expQ.pop_front();
                checkOutput("eng_addr", 32'(ENG_ADDR), 32'(expEntry[12:8]));
                checkOutput("eng_data", 32'(ENG_DATA), 32'(expEntry[7:0]));
            end
            if (ENG_ADDR == 5'd8) pendingM--;
        end
        if (busyTimer > 0) begin
            busyTimer--;
            if (busyTimer == 0) busyEngine = 1'b0;
        end
        if (ENG_CS === 1'b1 && ENG_ADDR == 5'd9) cntHi = ENG_DATA;
        if (ENG_CS === 1'b1 && ENG_ADDR == 5'd8 && {cntHi, ENG_DATA} != 16'h0000) begin
            busyEngine = 1'b1;
            busyTimer  = $urandom_range(1, 6);
            engineStarts++;
        end
    end

    // One CPU write, sampled on the posedge between the two negedges.
    task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
        @(negedge PHI2);
        CS   = 1'b1;
        RWB  = 1'b1;
        ADDR = addr;
        DIN  = data;
        @(negedge PHI2);
        CS   = 1'b0;
        RWB  = 1'b0;
    endtask

    task automatic cpuRead(input logic [3:0] addr, output logic [7:0] data);
        @(negedge PHI2);
        CS   = 1'b1;
        RWB  = 1'b0;
        ADDR = addr;
        #1;
        data = DOUT;
        CS   = 1'b0;
    endtask

    task automatic stageByte(input int off, input logic [7:0] val);
        applyStimulus(4'(off), val);
        stageM[off] = val;
    endtask

    // Reference queue: accept while fewer than DEPTH are pending, else OVF.
    task automatic doCommit();
        applyStimulus(COMMIT, 8'h00);
        if (pendingM < TB_DEPTH) begin
            for (int i = 0; i < 10; i++) begin
                expQ.push_back({5'(order[i]), stageM[order[i]]});
            end
            pendingM++;
        end else begin
            ovfM = 1'b1;
        end
    endtask

    function automatic logic [7:0] expStatus(input bit doneBit);
        logic [2:0] lvl;
        lvl = (pendingM > 7) ? 3'd7 : 3'(pendingM);
        return {irqenM, ovfM, doneBit, (pendingM >= TB_DEPTH), (pendingM == 0), lvl};
    endfunction

    task automatic waitDone(input int maxPolls, output bit seen);
        logic [7:0] s;
        seen = 1'b0;
        for (int i = 0; i < maxPolls; i++) begin
            cpuRead(STATUS, s);
            if (s[5]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic clearDone();
        applyStimulus(STATUS, {irqenM, 2'b01, 5'b00000});
    endtask

    task automatic randomDesc(input logic [7:0] saddLo);
        stageByte(0, saddLo);
        for (int b = 1; b < 10; b++) begin
            if ($urandom_range(0, 1) == 1) stageByte(b, 8'($urandom));
        end
    endtask

    // Main sequence.
    initial begin
        logic [7:0] rd;
        bit         seen;
        int         doneCount;
        int         n;
        int         startsBefore;

        for (int i = 0; i < 8; i++) order[i] = i;
        order[8] = 9;
        order[9] = 8;
        for (int i = 0; i < 10; i++) stageM[i] = 8'h00;
        RESET = 1'b1;
        CS    = 1'b0;
        RWB   = 1'b0;
        ADDR  = 4'h0;
        DIN   = 8'h00;
        repeat (3) @(negedge PHI2);
        RESET = 1'b0;

        // Reset values.
        checkOutput("reset_eng_cs", 32'(ENG_CS), 32'd0);
        checkOutput("reset_eng_rwb", 32'(ENG_RWB), 32'd0);
        checkOutput("reset_eng_addr", 32'(ENG_ADDR), 32'd0);
        checkOutput("reset_eng_data", 32'(ENG_DATA), 32'd0);
        checkOutput("reset_irq", 32'(IRQ), 32'd0);
        checkOutput("reset_dout_idle", 32'(DOUT), 32'd0);
        cpuRead(STATUS, rd);
        checkOutput("reset_status", 32'(rd), 32'(expStatus(1'b0)));

        // Single descriptor with commit-to-load latency.
        $display("[TB] single descriptor");
        stageByte(0, 8'h00); stageByte(1, 8'h10);
        stageByte(2, 8'h01); stageByte(3, 8'h00);
        stageByte(4, 8'h00); stageByte(5, 8'h20);
        stageByte(6, 8'h01); stageByte(7, 8'h00);
        stageByte(8, 8'h03); stageByte(9, 8'h00);
        cpuRead(4'd5, rd);
        checkOutput("staging_readback", 32'(rd), 32'h20);
        doCommit();
        checkOutput("latency_n1", 32'(ENG_CS), 32'd0);
        @(negedge PHI2);
        checkOutput("latency_n2", 32'(ENG_CS), 32'd0);
        @(negedge PHI2);
        checkOutput("latency_first_cs", 32'(ENG_CS), 32'd1);
        repeat (8) @(negedge PHI2);
        cpuRead(STATUS, rd);
        checkOutput("single_empty_after_pop", 32'(rd), 32'h08);
        waitDone(60, seen);
        checkOutput("single_done", 32'(seen), 32'd1);
        checkOutput("single_engine_started", 32'(engineStarts), 32'd1);
        cpuRead(STATUS, rd);
        checkOutput("single_status", 32'(rd), 32'(expStatus(1'b1)));
        clearDone();

        // Zero count: all writes, no engine start, DONE anyway.
        $display("[TB] zero count");
        stageByte(8, 8'h00);
        stageByte(9, 8'h00);
        startsBefore = engineStarts;
        doCommit();
        waitDone(30, seen);
        checkOutput("zero_done", 32'(seen), 32'd1);
        checkOutput("zero_no_engine_start", 32'(engineStarts), 32'(startsBefore));
        checkOutput("zero_all_writes", 32'(expQ.size()), 32'd0);
        clearDone();

        // Queue drain: three descriptors with distinct sadd, FIFO order.
        $display("[TB] queue drain");
        for (int k = 0; k < 3; k++) begin
            randomDesc(8'(k + 8'h41));
            doCommit();
        end
        doneCount = 0;
        for (int k = 0; k < 3; k++) begin
            waitDone(80, seen);
            if (seen) doneCount++;
            clearDone();
        end
        checkOutput("drain_done_count", 32'(doneCount), 32'd3);
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);

        // IRQ enable, completion, then clear DONE keeping IRQEN.
        $display("[TB] irq");
        irqenM = 1'b1;
        applyStimulus(STATUS, 8'h80);
        checkOutput("irq_before_done", 32'(IRQ), 32'd0);
        stageByte(8, 8'h05);
        doCommit();
        waitDone(60, seen);
        checkOutput("irq_done_seen", 32'(seen), 32'd1);
        checkOutput("irq_set", 32'(IRQ), 32'd1);
        applyStimulus(STATUS, 8'hA0);
        checkOutput("irq_cleared", 32'(IRQ), 32'd0);
        cpuRead(STATUS, rd);
        checkOutput("irq_status", 32'(rd), 32'(expStatus(1'b0)));

        // Overflow: engine held busy, five commits into four entries.
        $display("[TB] overflow");
        busyForce = 1'b1;
        for (int k = 0; k < 5; k++) begin
            randomDesc(8'(k + 8'h80));
            doCommit();
        end
        repeat (3) @(negedge PHI2);
        cpuRead(STATUS, rd);
        checkOutput("ovf_status", 32'(rd), 32'(expStatus(1'b0)));
        checkOutput("ovf_nothing_issued", 32'(expQ.size()), 32'd40);
        applyStimulus(STATUS, {irqenM, 1'b1, 6'b000000});
        ovfM = 1'b0;
        cpuRead(STATUS, rd);
        checkOutput("ovf_cleared", 32'(rd), 32'(expStatus(1'b0)));
        busyForce = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 4; k++) begin
            waitDone(80, seen);
            if (seen) doneCount++;
            clearDone();
        end
        checkOutput("ovf_drain_count", 32'(doneCount), 32'd4);
        repeat (40) @(negedge PHI2);
        checkOutput("ovf_fifth_never_issued", 32'(expQ.size()), 32'd0);

        // Reset during the fifth engine write.
        $display("[TB] reset mid-load");
        stageByte(8, 8'h07);
        doCommit();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PHI2);
            if (ENG_CS === 1'b1) n++;
            if (n == 5) break;
        end
        checkOutput("reset_found_5th_write", 32'(n), 32'd5);
        RESET = 1'b1;
        @(negedge PHI2);
        checkOutput("reset_eng_cs_next", 32'(ENG_CS), 32'd0);
        RESET = 1'b0;
        expQ.delete();
        pendingM = 0;
        irqenM   = 1'b0;
        ovfM     = 1'b0;
        for (int i = 0; i < 10; i++) stageM[i] = 8'h00;
        cpuRead(STATUS, rd);
        checkOutput("reset_mid_status", 32'(rd), 32'h08);
        checkOutput("reset_mid_irq", 32'(IRQ), 32'd0);
        cpuRead(4'd8, rd);
        checkOutput("reset_staging_zero", 32'(rd), 32'(stageM[8]));

        repeat (20) @(negedge PHI2);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 500000");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
